// File: rtl/wavetable_oscillator_if.sv
// Bus linking one oscillator voice to its note index ROM, the wavetable RAM and the mixer.
// The slave side is the oscillator; the master side is everything around it.
`timescale 1ns/1ps
interface wavetable_oscillator_if #(
   parameter int T_WIDTH = 8,
   parameter int I_WIDTH = 32,
   parameter int D_WIDTH = 16
);
   logic                      sampleTick;
   logic                      noteOn;
   logic [T_WIDTH-1:0]        tableIdx;
   logic [I_WIDTH-1:0]        tableInterp;
   logic [T_WIDTH-1:0]        waveAddr;
   logic signed [D_WIDTH-1:0] waveData;
   logic signed [D_WIDTH-1:0] sampleOut;
   logic                      sampleValid;
   logic                      busy;
   logic                      overrun;

   modport master (
      output sampleTick, noteOn, tableIdx, tableInterp, waveData,
      input  waveAddr, sampleOut, sampleValid, busy, overrun
   );

   modport slave (
      input  sampleTick, noteOn, tableIdx, tableInterp, waveData,
      output waveAddr, sampleOut, sampleValid, busy, overrun
   );
endinterface

// File: rtl/wavetable_oscillator.sv
// Wavetable oscillator voice: accumulates phase per sample tick, fetches two adjacent
// table entries from a synchronous RAM and emits one linearly interpolated sample.
`timescale 1ns/1ps
module wavetable_oscillator #(
   parameter int T_WIDTH = 8,
   parameter int I_WIDTH = 32,
   parameter int D_WIDTH = 16,
   parameter int F_WIDTH = 16
) (
   input logic Clk,
   input logic Reset_n,
   wavetable_oscillator_if.slave bus
);

   localparam int PW = D_WIDTH + F_WIDTH + 2;

   typedef enum logic [2:0] {IDLE, A1, C0, C1, MUL, OUT} state_t;

   state_t                    state, stateNext;
   logic [T_WIDTH-1:0]        phInt, incInt, waveAddr;
   logic [I_WIDTH-1:0]        phFrac, incFrac;
   logic [F_WIDTH-1:0]        frac;
   logic                      gate;
   logic signed [D_WIDTH-1:0] s0, s1, sampleOut, delta;
   logic [D_WIDTH:0]          diff;
   logic signed [PW-1:0]      prod, diffExt, fracExt;
   logic                      sampleValid, overrun, busy;

   // Both multiplier operands are widened to the full product width so the
   // truncated product equals the exact signed product.
   assign diff    = {s1[D_WIDTH-1], s1} - {s0[D_WIDTH-1], s0};
   assign diffExt = {{(F_WIDTH+1){diff[D_WIDTH]}}, diff};
   assign fracExt = {{(D_WIDTH+2){1'b0}}, frac};
   assign delta   = D_WIDTH'(prod >>> F_WIDTH);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (bus.sampleTick) begin
               stateNext = A1;
            end
         end
         A1:      stateNext = C0;
         C0:      stateNext = C1;
         C1:      stateNext = MUL;
         MUL:     stateNext = OUT;
         OUT:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         phInt       <= '0;
         phFrac      <= '0;
         incInt      <= '0;
         incFrac     <= '0;
         frac        <= '0;
         gate        <= 1'b0;
         waveAddr    <= '0;
         s0          <= '0;
         s1          <= '0;
         prod        <= '0;
         sampleOut   <= '0;
         sampleValid <= 1'b0;
      end else begin
         sampleValid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.sampleTick) begin
                  incInt   <= bus.tableIdx;
                  incFrac  <= bus.tableInterp;
                  gate     <= bus.noteOn;
                  frac     <= phFrac[I_WIDTH-1 -: F_WIDTH];
                  waveAddr <= phInt;
               end else if (!bus.noteOn) begin
                  phInt  <= '0;
                  phFrac <= '0;
               end
            end
            A1:  waveAddr <= phInt + T_WIDTH'(1);
            C0:  s0 <= bus.waveData;
            C1:  s1 <= bus.waveData;
            MUL: prod <= diffExt * fracExt;
            OUT: begin
               sampleValid <= 1'b1;
               if (gate) begin
                  sampleOut       <= s0 + delta;
                  {phInt, phFrac} <= {phInt, phFrac} + {incInt, incFrac};
               end else begin
                  sampleOut <= '0;
                  phInt     <= '0;
                  phFrac    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Sticky: any tick that the FSM cannot accept, including one on the OUT edge.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         overrun <= 1'b0;
      end else if (bus.sampleTick && state != IDLE) begin
         overrun <= 1'b1;
      end
   end

   assign bus.waveAddr    = waveAddr;
   assign bus.sampleOut   = sampleOut;
   assign bus.sampleValid = sampleValid;
   assign bus.busy        = busy;
   assign bus.overrun     = overrun;

endmodule

// File: tb/tb_wavetable_oscillator.sv
// Self-checking bench for wavetable_oscillator: directed scenarios plus randomized
// notes, compared against a phase-accumulator reference model with a RAM array.
`timescale 1ns/1ps
module tb_wavetable_oscillator;

   localparam int T_WIDTH = 8;
   localparam int I_WIDTH = 32;
   localparam int D_WIDTH = 16;
   localparam int F_WIDTH = 16;
   localparam longint PH_MASK = (64'sd1 <<< 40) - 1;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;

   wavetable_oscillator_if #(.T_WIDTH(T_WIDTH), .I_WIDTH(I_WIDTH), .D_WIDTH(D_WIDTH)) bus();

   wavetable_oscillator #(
      .T_WIDTH(T_WIDTH), .I_WIDTH(I_WIDTH), .D_WIDTH(D_WIDTH), .F_WIDTH(F_WIDTH)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .bus(bus)
   );

   always #5 Clk = ~Clk;

   // Synchronous wavetable RAM: address sampled at an edge, data valid after it.
   logic signed [15:0] mem [256];
   always @(posedge Clk) bus.waveData <= mem[bus.waveAddr];

   int compared = 0;
   int mismatched = 0;
   longint modelPhase = 0;

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference sample at the current model phase: integer part picks the pair,
   // top 16 fractional bits weight it, result floored toward minus infinity.
   function automatic longint modelSample(input bit gate);
      longint i0, f, a, b, d, q;
      i0 = (modelPhase >> 32) % 256;
      f  = (modelPhase >> 16) % 65536;
      a  = mem[i0];
      b  = mem[(i0 + 1) % 256];
      if (!gate) return 0;
      d = (b - a) * f;
      q = d / 65536;
      if (d < 0 && q * 65536 != d) q = q - 1;
      return a + q;
   endfunction

   function automatic void modelAdvance(input bit gate, input int idx, input longint interp);
      if (gate) modelPhase = (modelPhase + (longint'(idx) <<< 32) + interp) & PH_MASK;
      else      modelPhase = 0;
   endfunction

   task automatic resetDut();
      Reset_n = 1'b0;
      bus.sampleTick = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      modelPhase = 0;
   endtask

   // One accepted tick: checks busy, latency, value and pulse width, then idles gap cycles.
   task automatic applyStimulus(input string tag, input bit note, input int idx,
                                input longint interp, input bit dropNote, input int gap);
      longint expSample;
      int lat;
      @(negedge Clk);
      bus.sampleTick  = 1'b1;
      bus.noteOn      = note;
      bus.tableIdx    = idx[7:0];
      bus.tableInterp = interp[31:0];
      expSample = modelSample(note);
      @(posedge Clk);
      #1;
      bus.sampleTick = 1'b0;
      if (dropNote) bus.noteOn = 1'b0;
      checkOutput({tag, ".busyAfterAccept"}, longint'(bus.busy), 1);
      lat = 0;
      for (int k = 1; k <= 10 && lat == 0; k++) begin
         @(posedge Clk);
         #1;
         if (bus.sampleValid) lat = k;
      end
      checkOutput({tag, ".latency"}, lat, 5);
      checkOutput({tag, ".sample"}, longint'(bus.sampleOut), expSample);
      checkOutput({tag, ".busyDone"}, longint'(bus.busy), 0);
      modelAdvance(note, idx, interp);
      if (gap > 0) begin
         @(posedge Clk);
         #1;
         checkOutput({tag, ".validPulse"}, longint'(bus.sampleValid), 0);
         repeat (gap - 1) @(posedge Clk);
         #1;
         if (!bus.noteOn) modelPhase = 0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      longint expS;
      int validCount;
      bus.sampleTick  = 1'b0;
      bus.noteOn      = 1'b0;
      bus.tableIdx    = '0;
      bus.tableInterp = '0;
      for (int n = 0; n < 256; n++) mem[n] = (n < 100) ? 16'(100 * n) : 16'sd0;

      // Reset values
      #2;
      checkOutput("reset.sampleOut", longint'(bus.sampleOut), 0);
      checkOutput("reset.sampleValid", longint'(bus.sampleValid), 0);
      checkOutput("reset.busy", longint'(bus.busy), 0);
      checkOutput("reset.overrun", longint'(bus.overrun), 0);
      checkOutput("reset.waveAddr", longint'(bus.waveAddr), 0);
      resetDut();

      // Linear ramp: 0, 100, 200, 300 with a tick every 8 cycles
      for (int t = 0; t < 4; t++) applyStimulus($sformatf("ramp%0d", t), 1'b1, 1, 0, 1'b0, 2);
      checkOutput("ramp.lastValue", longint'(bus.sampleOut), 300);

      // Interpolation, positive then negative slope
      resetDut();
      mem[0] = 16'sd0; mem[1] = 16'sd1000; mem[2] = 16'sd1000;
      for (int t = 0; t < 3; t++) applyStimulus($sformatf("interp%0d", t), 1'b1, 0, 64'h8000_0000, 1'b0, 1);
      checkOutput("interp.third", longint'(bus.sampleOut), 1000);
      mem[1] = -16'sd1001;
      resetDut();
      for (int t = 0; t < 2; t++) applyStimulus($sformatf("interpNeg%0d", t), 1'b1, 0, 64'h8000_0000, 1'b0, 1);
      checkOutput("interpNeg.floor", longint'(bus.sampleOut), -501);

      // Wrap-around of phase and of the second fetch address
      resetDut();
      for (int n = 0; n < 256; n++) mem[n] = 16'(n);
      for (int t = 0; t < 3; t++) applyStimulus($sformatf("wrap%0d", t), 1'b1, 255, 0, 1'b0, 1);
      checkOutput("wrap.third", longint'(bus.sampleOut), 254);
      resetDut();
      mem[255] = 16'sd100; mem[0] = 16'sd300;
      for (int t = 0; t < 2; t++) applyStimulus($sformatf("wrapInterp%0d", t), 1'b1, 255, 64'h8000_0000, 1'b0, 1);
      checkOutput("wrapInterp.second", longint'(bus.sampleOut), 200);

      // Gate handling, including noteOn dropped right after acceptance
      resetDut();
      for (int n = 0; n < 256; n++) mem[n] = 16'(100 * n + 7);
      for (int t = 0; t < 3; t++) applyStimulus($sformatf("gateOff%0d", t), 1'b0, 1, 0, 1'b0, 1);
      applyStimulus("gateOn0", 1'b1, 1, 0, 1'b0, 1);
      applyStimulus("gateOn1", 1'b1, 1, 0, 1'b0, 1);
      applyStimulus("gateDrop", 1'b1, 1, 0, 1'b1, 2);
      checkOutput("gateDrop.value", longint'(bus.sampleOut), 207);
      applyStimulus("gateRestart", 1'b1, 1, 0, 1'b0, 1);
      checkOutput("gateRestart.value", longint'(bus.sampleOut), 7);

      // Overrun: second tick two cycles after the first is dropped
      resetDut();
      checkOutput("overrun.clearAfterReset", longint'(bus.overrun), 0);
      expS = modelSample(1'b1);
      @(negedge Clk);
      bus.sampleTick = 1'b1; bus.noteOn = 1'b1; bus.tableIdx = 8'd1; bus.tableInterp = '0;
      @(posedge Clk); #1; bus.sampleTick = 1'b0;
      @(posedge Clk);
      @(negedge Clk); bus.sampleTick = 1'b1;
      @(posedge Clk); #1; bus.sampleTick = 1'b0;
      validCount = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge Clk);
         #1;
         if (bus.sampleValid) validCount++;
      end
      checkOutput("overrun.validCount", validCount, 1);
      checkOutput("overrun.sample", longint'(bus.sampleOut), expS);
      checkOutput("overrun.flag", longint'(bus.overrun), 1);
      modelAdvance(1'b1, 1, 0);
      applyStimulus("overrunLater", 1'b1, 1, 0, 1'b0, 1);
      checkOutput("overrun.sticky", longint'(bus.overrun), 1);

      // Asynchronous reset while the FSM sits in MUL
      @(negedge Clk);
      bus.sampleTick = 1'b1;
      @(posedge Clk); #1; bus.sampleTick = 1'b0;
      repeat (3) @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      checkOutput("midReset.sampleOut", longint'(bus.sampleOut), 0);
      checkOutput("midReset.sampleValid", longint'(bus.sampleValid), 0);
      checkOutput("midReset.waveAddr", longint'(bus.waveAddr), 0);
      checkOutput("midReset.busy", longint'(bus.busy), 0);
      checkOutput("midReset.overrun", longint'(bus.overrun), 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      modelPhase = 0;
      validCount = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge Clk);
         #1;
         if (bus.sampleValid) validCount++;
      end
      checkOutput("midReset.noStaleSample", validCount, 0);
      applyStimulus("midReset.first", 1'b1, 1, 0, 1'b0, 1);
      checkOutput("midReset.firstValue", longint'(bus.sampleOut), 7);

      // Randomized notes against the reference model
      resetDut();
      for (int n = 0; n < 256; n++) mem[n] = 16'($urandom);
      for (int t = 0; t < 40; t++) begin
         applyStimulus($sformatf("rand%0d", t), ($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
                       longint'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
      end
      checkOutput("rand.noOverrun", longint'(bus.overrun), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/wavetable_oscillator.md
Name: wavetable_oscillator

Overview:
- Downstream consumer of the note-to-table-index ROM.
- Takes the per-note integer/fractional phase increment (tableIdx/tableInterp), accumulates phase once per sample tick, and fetches two adjacent samples from an external synchronous wavetable RAM.
- Outputs one linearly interpolated signed sample per tick, which feeds the voice mixer.

Parameters:
- T_WIDTH, 8: wavetable address width and integer phase width (table length 2**T_WIDTH).
- I_WIDTH, 32: fractional phase and fractional increment width.
- D_WIDTH, 16: signed sample width.
- F_WIDTH, 16: interpolation fraction width, taken from the top F_WIDTH bits of the fractional phase (F_WIDTH <= I_WIDTH).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- sampleTick  in  1  one-cycle strobe at the audio sample rate.
- noteOn  in  1  gate for the voice.
- tableIdx  in  T_WIDTH  integer phase increment from the index ROM.
- tableInterp  in  I_WIDTH  fractional phase increment from the index ROM.
- waveAddr  out  T_WIDTH  wavetable RAM read address, registered.
- waveData  in  D_WIDTH  signed RAM read data; valid 1 cycle after the address is registered by the RAM (RAM samples waveAddr at an edge and drives data after that edge).
- sampleOut  out  D_WIDTH  signed interpolated sample, held between updates.
- sampleValid  out  1  one-cycle pulse when sampleOut updates.
- busy  out  1  high whenever the FSM is not in IDLE.
- overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset (async, Reset_n=0): state IDLE; phase {phInt,phFrac}=0; waveAddr=0; sampleOut=0; sampleValid=0; busy=0; overrun=0. Any in-flight computation is abandoned. No sample is produced for that computation after release.
- Phase register: T_WIDTH+I_WIDTH bits, {phInt,phFrac}, unsigned. Addition wraps modulo 2**(T_WIDTH+I_WIDTH).
- FSM states: IDLE, A1, C0, C1, MUL, OUT. E0 is the edge at which a tick is accepted.
  - IDLE: when sampleTick=1 at edge E0, go to A1. At the same edge:
    - latch incInt<=tableIdx, incFrac<=tableInterp, gate<=noteOn, frac<=phFrac[I_WIDTH-1 -: F_WIDTH];
    - waveAddr<=phInt.
    - While in IDLE with noteOn=0 and no tick, the phase is cleared to 0.
  - A1 (E1): waveAddr<=phInt+1, wrapping mod 2**T_WIDTH (255 -> 0). Go to C0.
  - C0 (E2): s0<=waveData. Go to C1.
  - C1 (E3): s1<=waveData. Go to MUL.
  - MUL (E4): prod<=(s1-s0)*frac.
    - s1-s0 is signed, D_WIDTH+1 bits.
    - frac is zero-extended (unsigned).
    - prod is signed, D_WIDTH+F_WIDTH+2 bits.
    - Go to OUT.
  - OUT (E5): sampleValid<=1 for exactly this one cycle. Go to IDLE.
    - If gate=1: sampleOut<=s0+(prod>>>F_WIDTH) (arithmetic shift, floor toward -inf), truncated to D_WIDTH. The result always lies between s0 and s1, so it never overflows. Phase<=phase+{incInt,incFrac}.
    - If gate=0: sampleOut<=0; phase<=0.
- Latency: sampleValid is high in the cycle after E5, i.e. 5 edges after the accepting edge. Minimum tick spacing is 6 cycles.
- Increments, gate and frac are latched at E0. Changes to tableIdx, tableInterp or noteOn mid-computation affect only the next sample.
- A tick while busy (states A1..OUT) is ignored and sets overrun=1. overrun clears only on reset.
- A tick coincident with the OUT edge is also ignored and sets overrun. IDLE must be reached first.
- busy=1 in A1, C0, C1, MUL, OUT; busy=0 in IDLE.
- waveAddr holds its last value outside A1/IDLE-accept edges.

Test Plan:
1. Linear ramp: RAM[n]=100*n (n<100), noteOn=1, tableIdx=1, tableInterp=0, tick every 8 cycles -> sampleOut 0,100,200,300. sampleValid exactly 5 edges after each accepting edge. busy high for 5 cycles per tick.
2. Interpolation with signed rounding: RAM[0]=0, RAM[1]=1000, RAM[2]=1000, tableIdx=0, tableInterp=0x8000_0000 -> 0, 500, 1000. Then RAM[1]=-1001, reset, same stimulus -> 0, -501 (floor of -500.5).
3. Wrap-around: RAM[n]=n, tableIdx=255, tableInterp=0 -> 0, 255, 254. With tableIdx=255, tableInterp=0x8000_0000, RAM[255]=100, RAM[0]=300, the second sample reads addresses 255 then 0 -> 200.
4. Gate: noteOn=0 for 3 ticks -> sampleOut=0 with sampleValid pulses. Raise noteOn with tableIdx=1 -> first sample RAM[0], then RAM[1]. Dropping noteOn after E0 still yields a normal sample for that tick.
5. Overrun: ticks 2 cycles apart -> exactly one sampleValid, overrun=1 and staying 1 through later normal ticks until Reset_n=0.
6. Reset mid-operation: Reset_n low during MUL -> sampleOut, sampleValid, waveAddr, busy and overrun are 0 immediately, without a clock edge. After release, first tick with tableIdx=1 yields RAM[0].
